// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: boots from a reset vector in instruction memory, then
// streams sequential fetches into a DEPTH-entry prefetch queue drained by decode.
module fetch_queue_unit #(
  parameter int          ADDR_W    = 18,
  parameter int          DEPTH     = 4,
  parameter int unsigned BOOT_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump,
  input  logic [31:0]       target,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              booting
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BOOT_REQ, BOOT_WAIT, RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_req_pc;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [31:0]       r_q_pc    [DEPTH];
  logic [31:0]       r_q_instr [DEPTH];

  logic              w_issue;
  logic              w_credit;
  logic              w_run_jump;
  logic              w_push;
  logic              w_pop;

  // Queued entries plus the outstanding read must fit, so a response always has a slot.
  assign w_credit   = ({1'b0, r_count} + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(DEPTH);
  assign w_run_jump = (r_state == RUN) && jump;
  assign w_push     = r_inflight && !jump;
  assign out_valid  = !rst && (r_count != '0);
  assign w_pop      = out_valid && out_ready;
  assign out_pc     = r_q_pc[r_rptr];
  assign out_instr  = r_q_instr[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT_REQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT_REQ:  w_state_nxt = BOOT_WAIT;
      BOOT_WAIT: w_state_nxt = RUN;
      RUN:       w_state_nxt = RUN;
      default:   w_state_nxt = BOOT_REQ;
    endcase
  end

  always_comb begin
    imem_en   = 1'b0;
    imem_addr = r_fetch_pc[ADDR_W+1:2];
    booting   = 1'b1;
    w_issue   = 1'b0;
    if (!rst) begin
      case (r_state)
        BOOT_REQ: begin
          imem_en   = 1'b1;
          imem_addr = ADDR_W'(BOOT_ADDR);
        end
        RUN: begin
          booting = 1'b0;
          w_issue = w_credit && !jump;
          imem_en = w_issue;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= '0;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (r_state == BOOT_WAIT)
        r_fetch_pc <= imem_rdata & 32'hFFFF_FFFC;
      else if (w_run_jump)
        r_fetch_pc <= target & 32'hFFFF_FFFC;
      else if (w_issue)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      r_inflight <= w_issue;
      if (w_issue) r_req_pc <= r_fetch_pc;
      if (w_run_jump) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wptr]    <= r_req_pc;
      r_q_instr[r_wptr] <= imem_rdata;
    end
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised next-generation instruction fetch stage for the MIPS core.
- Boots by reading a reset vector from instruction memory, then streams sequential fetches into a DEPTH-entry prefetch queue.
- Decode consumes the queue through a valid/ready handshake; jumps redirect the stream and flush everything queued or in flight.
- Instruction memory is external, synchronous, with 1-cycle read latency.

Parameters:
- ADDR_W, 18, instruction-memory word-address width (imem_addr = pc[ADDR_W+1:2]).
- DEPTH, 4, prefetch-queue entries; power of two, minimum 2.
- BOOT_ADDR, 0, word address holding the 32-bit reset vector.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- jump  in  1  redirect request, single cycle.
- target  in  32  redirect PC.
- imem_en  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  word address of the read.
- imem_rdata  in  32  read data, valid the cycle after imem_en.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  32  PC of head instruction.
- out_instr  out  32  head instruction.
- booting  out  1  high while the reset vector is being fetched.

Behaviour:
- Reset (rst=1 at posedge):
  - State=BOOT_REQ, queue empty, in-flight flag cleared, fetch_pc=0.
  - Outputs: out_valid=0, imem_en=0, booting=1.
  - Reset has priority over every other input in every state, mid-operation included.
- FSM states: BOOT_REQ, BOOT_WAIT, RUN.
- BOOT_REQ: imem_en=1, imem_addr=BOOT_ADDR; next state BOOT_WAIT.
- BOOT_WAIT: fetch_pc <= {imem_rdata[31:2],2'b00}; next state RUN; booting drops to 0 on entry to RUN.
- jump is ignored in BOOT_REQ and BOOT_WAIT.
- RUN fetch issue:
  - imem_en=1 when count + inflight < DEPTH and jump=0.
  - imem_addr=fetch_pc[ADDR_W+1:2]; the issued PC is captured in req_pc; fetch_pc += 4.
  - At most one read issued per cycle.
- RUN response:
  - The cycle after an issue, {req_pc, imem_rdata} is pushed at the tail, unless the response was killed by a jump.
  - The credit check above guarantees the queue never overflows.
- Handshake:
  - out_valid = (count != 0); out_pc/out_instr = head entry, combinational from queue storage.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Head fields are held stable while out_valid && !out_ready.
- Throughput: with out_ready held at 1, one instruction is delivered per cycle after the initial fill.
- Latency:
  - From entering RUN to first out_valid: 2 cycles (issue, then push; visible the following cycle).
  - From the first imem_en in BOOT_REQ: 4 cycles.
- Jump (RUN, jump=1):
  - Queue flushed (count=0), so out_valid=0 next cycle.
  - Any in-flight response is discarded.
  - fetch_pc <= {target[31:2],2'b00}; no issue that cycle.
  - A pop requested in the same cycle is still treated as consumed; decode owns that ordering.
- Wrap-around:
  - fetch_pc wraps modulo 2^32.
  - imem_addr wraps modulo 2^ADDR_W (upper PC bits are ignored).
  - Queue read/write pointers are log2(DEPTH) bits and wrap naturally.
- Full: count==DEPTH ⇒ no issue.
- Empty: count==0 ⇒ out_valid=0, and out_ready has no effect.
- Count width: log2(DEPTH)+1 bits.

Test Plan:
- Boot: rst 1→0; mem[0]=0x00000040, mem[16..]=I0,I1… → booting=1 for 2 cycles; first out_valid with out_pc=0x40, out_instr=I0; next beat out_pc=0x44.
- Streaming: out_ready=1 constant → consecutive beats with PC +4 each cycle and no bubbles after fill.
- Backpressure: out_ready=0 for 10 cycles → count saturates at DEPTH=4, imem_en=0 once full; head PC stays 0x40; release → 0x40,0x44,0x48,0x4C,0x50 in order, none lost or duplicated.
- Jump with in-flight read: jump=1, target=0x203 while the queue is partially full → out_valid=0 next cycle; the stale response is dropped; next delivered out_pc=0x200.
- Jump during BOOT_WAIT plus misaligned vector: mem[0]=0x00000042 → jump ignored; first out_pc=0x40.
- Reset mid-stream: rst=1 for 1 cycle with 3 entries queued → out_valid=0, booting=1 next cycle; boot sequence restarts from BOOT_ADDR.
